// File: rtl/bram_dp.sv
// bram_dp: one-write / two-read block RAM with byte enables.
// After reset it can zero-fill itself.
// Port A reads and writes; port B only reads. Reads have 1 or 2 cycles of latency.
// Reads that collide with the port A write are resolved by RDW_MODE.
//
// Controller states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_CLEAR | zero-filling addresses 0..MEMORY_DEPTH-1, user strobes ignored
//   ST_READY | normal operation, user reads/writes accepted
module bram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEMORY_DEPTH   = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_wr_en,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic                    a_rd_en,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  output logic [DATA_WIDTH-1:0]   a_rd_data,
  output logic                    a_rd_valid,
  input  logic                    b_rd_en,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0]   b_rd_data,
  output logic                    b_rd_valid,
  output logic                    init_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // One extra bit so the range compare also works when MEMORY_DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;

  logic                  a_in_range;
  logic                  b_in_range;
  logic                  user_we;
  logic                  fill_we;
  logic                  a_rd_fire;
  logic                  b_rd_fire;
  logic [DATA_WIDTH-1:0] a_mem_word;
  logic [DATA_WIDTH-1:0] b_mem_word;
  logic [DATA_WIDTH-1:0] a_rd_word;
  logic [DATA_WIDTH-1:0] b_rd_word;

  logic                  a_s1_valid;
  logic [DATA_WIDTH-1:0] a_s1_data;
  logic                  b_s1_valid;
  logic [DATA_WIDTH-1:0] b_s1_data;

  // Returns the word as it looks after a byte-enabled write lands on it.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

  assign ready     = (state == ST_READY);
  assign init_busy = (state == ST_CLEAR);

  assign a_in_range = ({1'b0, a_addr} < DEPTH_EXT);
  assign b_in_range = ({1'b0, b_addr} < DEPTH_EXT);

  // A write to an out-of-range address is dropped, so the address never wraps onto a real word.
  assign user_we   = ready && a_wr_en && a_in_range;
  assign fill_we   = !ready;
  assign a_rd_fire = ready && a_rd_en;
  assign b_rd_fire = ready && b_rd_en;

  // Fill controller: walk the address space once, then hand over to the user ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RESET;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state    <= ST_READY;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // Storage array: the fill sequence and the byte-enabled user writes share one write port.
  // There is no reset here, so reset never changes memory contents.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wr_data[8*i +: 8];
      end
    end
  end

  // Read word selection.
  // An out-of-range address reads as zero.
  // In write-first mode, a read that collides with the port A write sees the merged word.
  always_comb begin
    a_mem_word = '0;
    b_mem_word = '0;
    if (a_in_range) a_mem_word = mem[a_addr];
    if (b_in_range) b_mem_word = mem[b_addr];
    a_rd_word = a_mem_word;
    b_rd_word = b_mem_word;
    if (RDW_MODE != 0) begin
      if (user_we) a_rd_word = merge_bytes(a_mem_word, a_wr_data, a_be);
      if (user_we && (b_addr == a_addr)) b_rd_word = merge_bytes(b_mem_word, a_wr_data, a_be);
    end
  end

  // First read stage.
  // The data register loads only when a read completes, so the output holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_s1_valid <= 1'b0;
      a_s1_data  <= '0;
      b_s1_valid <= 1'b0;
      b_s1_data  <= '0;
    end else begin
      a_s1_valid <= a_rd_fire;
      b_s1_valid <= b_rd_fire;
      if (a_rd_fire) a_s1_data <= a_rd_word;
      if (b_rd_fire) b_s1_data <= b_rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  a_s2_valid;
      logic [DATA_WIDTH-1:0] a_s2_data;
      logic                  b_s2_valid;
      logic [DATA_WIDTH-1:0] b_s2_data;

      // Optional output register stage; it holds its data in the same way as stage 1.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_s2_valid <= 1'b0;
          a_s2_data  <= '0;
          b_s2_valid <= 1'b0;
          b_s2_data  <= '0;
        end else begin
          a_s2_valid <= a_s1_valid;
          b_s2_valid <= b_s1_valid;
          if (a_s1_valid) a_s2_data <= a_s1_data;
          if (b_s1_valid) b_s2_data <= b_s1_data;
        end
      end

      assign a_rd_data  = a_s2_data;
      assign a_rd_valid = a_s2_valid;
      assign b_rd_data  = b_s2_data;
      assign b_rd_valid = b_s2_valid;
    end else begin : g_lat1
      assign a_rd_data  = a_s1_data;
      assign a_rd_valid = a_s1_valid;
      assign b_rd_data  = b_s1_data;
      assign b_rd_valid = b_s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: drives the same stimulus into two bram_dp instances.
//   dut 0: depth 1000, latency 1, read-first
//   dut 1: depth 1024, latency 2, write-first
// A word-array reference model produces expected reads.
// A monitor pops them as valids appear.
module tb_bram_dp;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_wr_en = 1'b0;
  logic [3:0]  a_be = 4'h0;
  logic        a_rd_en = 1'b0;
  logic [9:0]  a_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        b_rd_en = 1'b0;
  logic [9:0]  b_addr = '0;

  logic [31:0] a0_d, b0_d, a1_d, b1_d;
  logic        a0_v, b0_v, a1_v, b1_v;
  logic        busy0, busy1;

  int          cyc = 0;
  int          rel_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  exp_t        q [4][$];
  logic [31:0] last [4];
  logic [31:0] m [2][1024];

  bram_dp #(.DATA_WIDTH(32), .MEMORY_DEPTH(1000), .ADDR_WIDTH(10), .RD_LATENCY(1),
            .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .a_wr_en(a_wr_en), .a_be(a_be), .a_rd_en(a_rd_en),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_rd_data(a0_d), .a_rd_valid(a0_v),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd_data(b0_d), .b_rd_valid(b0_v),
    .init_busy(busy0));

  bram_dp #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024), .ADDR_WIDTH(10), .RD_LATENCY(2),
            .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .a_wr_en(a_wr_en), .a_be(a_be), .a_rd_en(a_rd_en),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_rd_data(a1_d), .a_rd_valid(a1_v),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd_data(b1_d), .b_rd_valid(b1_v),
    .init_busy(busy1));

  always #5 clk = ~clk;

  // Cycle count, and the number of clock edges since reset was released.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) rel_cnt <= 0;
    else      rel_cnt <= rel_cnt + 1;
  end

  function automatic int depth_of(input int d);
    return (d == 0) ? 1000 : 1024;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act,
                              input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Reference behaviour of one instance for one issued cycle.
  function automatic void model(input int d, input logic we, input logic [3:0] be,
                                input logic [9:0] aa, input logic [31:0] wd,
                                input logic re_a, input logic re_b, input logic [9:0] ba);
    exp_t e;
    bit   wr_ok;
    if (!(rst && rel_cnt >= depth_of(d))) return;
    wr_ok = we && (int'(aa) < depth_of(d));
    if (re_a) begin
      e.data = (int'(aa) < depth_of(d)) ? m[d][aa] : 32'h0;
      if (d == 1 && wr_ok) e.data = byte_merge(e.data, wd, be);
      e.cyc = cyc + lat_of(d);
      q[2*d].push_back(e);
    end
    if (re_b) begin
      e.data = (int'(ba) < depth_of(d)) ? m[d][ba] : 32'h0;
      if (d == 1 && wr_ok && ba == aa) e.data = byte_merge(e.data, wd, be);
      e.cyc = cyc + lat_of(d);
      q[2*d+1].push_back(e);
    end
    if (wr_ok) m[d][aa] = byte_merge(m[d][aa], wd, be);
  endfunction

  task automatic step(input logic we, input logic [3:0] be, input logic [9:0] aa,
                      input logic [31:0] wd, input logic re_a, input logic re_b,
                      input logic [9:0] ba);
    @(negedge clk);
    a_wr_en = we; a_be = be; a_addr = aa; a_wr_data = wd;
    a_rd_en = re_a; b_rd_en = re_b; b_addr = ba;
    model(0, we, be, aa, wd, re_a, re_b, ba);
    model(1, we, be, aa, wd, re_a, re_b, ba);
  endtask

  task automatic rand_addr(output logic [9:0] ad);
    case ($urandom_range(0, 3))
      0:       ad = 10'($urandom_range(0, 15));
      1:       ad = 10'($urandom_range(990, 1023));
      default: ad = 10'($urandom_range(0, 1023));
    endcase
  endtask

  task automatic rand_step();
    logic [9:0] aa, ba;
    rand_addr(aa);
    rand_addr(ba);
    if ($urandom_range(0, 2) == 0) ba = aa;
    step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), aa, $urandom,
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ba);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    rst = 1'b0;
    a_wr_en = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) m[d][i] = 32'h0;
    #1;
    chk(a0_d === 32'h0 && b0_d === 32'h0 && a1_d === 32'h0 && b1_d === 32'h0,
        "reset_data_immediate", a0_d | b0_d | a1_d | b1_d, 32'h0);
    chk(!a0_v && !b0_v && !a1_v && !b1_v, "reset_valid_immediate",
        {28'h0, a0_v, b0_v, a1_v, b1_v}, 32'h0);
    chk(busy0 && busy1, "reset_busy", {30'h0, busy0, busy1}, 32'h3);
    repeat (hold) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic check_port(input int i, input logic v, input logic [31:0] d, input string nm);
    exp_t e;
    if (v) begin
      if (q[i].size() == 0) begin
        chk(1'b0, {nm, "_unexpected_valid"}, d, 32'h0);
      end else begin
        e = q[i].pop_front();
        chk(d === e.data, {nm, "_data"}, d, e.data);
        chk(cyc == e.cyc, {nm, "_latency"}, 32'(cyc), 32'(e.cyc));
        last[i] = e.data;
      end
    end else begin
      chk(d === last[i], {nm, "_hold"}, d, last[i]);
      if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
        e = q[i].pop_front();
        chk(1'b0, {nm, "_missing_valid"}, 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  // Monitor: compares on the falling edge, away from the edge that updates the DUT.
  always @(negedge clk) begin
    chk(busy0 === (!rst || rel_cnt < 1000), "init_busy0", {31'h0, busy0},
        {31'h0, (!rst || rel_cnt < 1000)});
    chk(busy1 === (!rst || rel_cnt < 1024), "init_busy1", {31'h0, busy1},
        {31'h0, (!rst || rel_cnt < 1024)});
    if (!rst) begin
      chk(a0_d === 32'h0 && !a0_v && b0_d === 32'h0 && !b0_v &&
          a1_d === 32'h0 && !a1_v && b1_d === 32'h0 && !b1_v,
          "outputs_in_reset", a0_d | b0_d | a1_d | b1_d, 32'h0);
      for (int i = 0; i < 4; i++) last[i] = 32'h0;
    end else begin
      check_port(0, a0_v, a0_d, "dut0_a");
      check_port(1, b0_v, b0_d, "dut0_b");
      check_port(2, a1_v, a1_d, "dut1_a");
      check_port(3, b1_v, b1_d, "dut1_b");
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) last[i] = 32'h0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) m[d][i] = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Random strobes while the fill runs; they must be ignored.
    // Then reset the blocks around fill address 500.
    for (int i = 0; i < 600 && rel_cnt < 500; i++) rand_step();
    do_reset(3);

    // Full fill after the restart.
    // dut0 becomes ready 24 cycles before dut1.
    for (int i = 0; i < 1030; i++) rand_step();

    step(0, 4'h0, 10'd1023, 32'h0, 1, 1, 10'd1023);
    step(1, 4'hF, 10'd5, 32'hAABBCCDD, 0, 0, 10'd0);
    step(1, 4'h5, 10'd5, 32'h11223344, 0, 0, 10'd0);
    step(0, 4'h0, 10'd5, 32'h0, 1, 1, 10'd5);
    step(1, 4'h0, 10'd5, 32'hFFFFFFFF, 0, 0, 10'd0);
    step(0, 4'h0, 10'd5, 32'h0, 1, 0, 10'd0);
    step(1, 4'hF, 10'd1, 32'h1, 0, 0, 10'd0);
    step(1, 4'hF, 10'd2, 32'h2, 0, 0, 10'd0);
    step(1, 4'hF, 10'd3, 32'h3, 0, 0, 10'd0);
    step(0, 4'h0, 10'd0, 32'h0, 0, 1, 10'd1);
    step(0, 4'h0, 10'd0, 32'h0, 0, 1, 10'd2);
    step(0, 4'h0, 10'd0, 32'h0, 0, 1, 10'd3);
    step(1, 4'hF, 10'd7, 32'h0, 0, 0, 10'd0);
    step(1, 4'hF, 10'd7, 32'hFFFFFFFF, 0, 1, 10'd7);
    step(0, 4'h0, 10'd7, 32'h0, 1, 0, 10'd0);
    step(1, 4'hF, 10'd1010, 32'hDEADBEEF, 0, 0, 10'd0);
    step(0, 4'h0, 10'd1010, 32'h0, 1, 1, 10'd1010);
    step(0, 4'h0, 10'd0, 32'h0, 0, 0, 10'd0);

    // Read back the whole in-range space of dut0 on both ports.
    for (int i = 0; i < 1000; i++) step(0, 4'h0, 10'(i), 32'h0, 1, 1, 10'(999 - i));

    for (int i = 0; i < 3000; i++) rand_step();

    // Reset while reads are still in flight.
    step(0, 4'h0, 10'd5, 32'h0, 1, 1, 10'd5);
    do_reset(2);
    for (int i = 0; i < 1030; i++) rand_step();
    for (int i = 0; i < 200; i++) rand_step();

    for (int i = 0; i < 6; i++) step(0, 4'h0, 10'd0, 32'h0, 0, 0, 10'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk(q[i].size() == 0, "queue_drained", 32'(q[i].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_dp.md
BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, address width; MEMORY_DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0, read-during-write mode: 0 = read-first (old data), 1 = write-first (new data).
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the memory after reset.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port a_wr_en  input  1  port A write strobe.
REQ-010 SHALL have port a_be  input  DATA_WIDTH/8  port A byte enables; bit i gates bits [8i+7:8i].
REQ-011 SHALL have port a_rd_en  input  1  port A read strobe.
REQ-012 SHALL have port a_addr  input  ADDR_WIDTH  port A address.
REQ-013 SHALL have port a_wr_data  input  DATA_WIDTH  port A write data.
REQ-014 SHALL have port a_rd_data  output  DATA_WIDTH  port A read data.
REQ-015 SHALL have port a_rd_valid  output  1  one-cycle pulse qualifying a_rd_data.
REQ-016 SHALL have port b_rd_en  input  1  port B (read-only) read strobe.
REQ-017 SHALL have port b_addr  input  ADDR_WIDTH  port B address.
REQ-018 SHALL have port b_rd_data  output  DATA_WIDTH  port B read data.
REQ-019 SHALL have port b_rd_valid  output  1  one-cycle pulse qualifying b_rd_data.
REQ-020 SHALL have port init_busy  output  1  high while the zero-fill sequence runs.

Function
REQ-021 SHALL implement a two-state controller, CLEAR and READY; from reset it enters CLEAR when CLEAR_ON_RESET=1, otherwise READY.
REQ-022 In CLEAR, the block SHALL write all-zero words to addresses 0..MEMORY_DEPTH-1, one per cycle, then enter READY on the cycle after address MEMORY_DEPTH-1; init_busy SHALL be 1 exactly while in CLEAR.
REQ-023 In CLEAR, the block SHALL ignore all user strobes: no writes, and no rd_valid pulses.
REQ-024 In READY, a write SHALL occur when a_wr_en=1 and a_addr<MEMORY_DEPTH; only bytes with a_be[i]=1 are updated, and a_be=0 writes nothing.
REQ-025 A read on port X, issued when X_rd_en=1 at cycle N in READY, SHALL present X_rd_data with X_rd_valid=1 at cycle N+RD_LATENCY; RD_LATENCY=2 adds an output register stage.
REQ-026 Ports A and B SHALL accept a read every cycle, independently (full throughput, no backpressure).
REQ-027 A read of any address >= MEMORY_DEPTH SHALL return 0, with valid asserted normally.
REQ-028 X_rd_data SHALL hold its last value when no read completes; X_rd_valid SHALL be 0 in that cycle.
REQ-029 A read of the address being written in the same cycle, on either port, SHALL return the pre-write word when RDW_MODE=0.
REQ-030 Under the same collision with RDW_MODE=1, the read SHALL return the merged word: new bytes where a_be=1, old bytes elsewhere.

Reset
REQ-031 Asserting rst=0 SHALL immediately force a_rd_data=0, b_rd_data=0, a_rd_valid=0 and b_rd_valid=0, and flush the pipeline stages.
REQ-032 While rst=0, init_busy SHALL be 1 if CLEAR_ON_RESET=1, else 0.
REQ-033 Memory contents SHALL NOT be altered asynchronously by reset.
REQ-034 A reset asserted during CLEAR SHALL restart the fill from address 0 after release.

Verification
REQ-035 Fill check, CLEAR_ON_RESET=1, MEMORY_DEPTH=1024: release rst -> init_busy high for exactly 1024 cycles; a subsequent read of address 1023 returns 0x00000000.
REQ-036 Byte enables: write 0xAABBCCDD to addr 5, then a_be=4'b0101 with data 0x11223344 -> read of addr 5 returns 0xAA22CC44.
REQ-037 Latency: RD_LATENCY=2 with back-to-back b_rd_en on addrs 1,2,3 (contents 0x1,0x2,0x3) -> valid on cycles N+2..N+4 with data 0x1,0x2,0x3.
REQ-038 Collision: addr 7 holds 0x0 and is written 0xFFFFFFFF while port B reads addr 7 -> b_rd_data=0x0 when RDW_MODE=0, 0xFFFFFFFF when RDW_MODE=1.
REQ-039 Out-of-range: MEMORY_DEPTH=1000, ADDR_WIDTH=10; write to addr 1010, then read addr 1010 -> returns 0, and addr 1010-1024=... no aliasing: addrs 0..999 are unchanged.
REQ-040 Reset mid-fill: rst=0 at fill address 500, released 3 cycles later -> outputs 0 during reset; fill restarts at address 0 and lasts 1024 cycles.
